// File: rtl/ysyx_041461_if1_fetch.sv
// IF1 fetch stage: owns the fetch PC, issues one single-beat 64-bit AXI4 read
// per instruction, and presents the result (or a fetch trap) to the IF2 register.

`ifndef ysyx_041461_TRAP_NOP
`define ysyx_041461_TRAP_NOP 4'd0
`endif
`ifndef ysyx_041461_TRAP_INST_MISALIGN
`define ysyx_041461_TRAP_INST_MISALIGN 4'd1
`endif
`ifndef ysyx_041461_TRAP_INST_ACCESS
`define ysyx_041461_TRAP_INST_ACCESS 4'd2
`endif

module ysyx_041461_if1_fetch #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_3000_0000
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,

    input  logic        IF1_ready_in,
    output logic [63:0] IF1_pc_out,
    output logic [63:0] IF1_rdata_out,
    output logic        IF1_valid_out,
    output logic [3:0]  IF1_trap_out,

    output logic        arvalid,
    input  logic        arready,
    output logic [63:0] araddr,
    output logic [7:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,

    input  logic        rvalid,
    output logic        rready,
    input  logic [63:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rlast
);

    localparam logic [3:0] TRAP_NOP           = `ysyx_041461_TRAP_NOP;
    localparam logic [3:0] TRAP_INST_MISALIGN = `ysyx_041461_TRAP_INST_MISALIGN;
    localparam logic [3:0] TRAP_INST_ACCESS   = `ysyx_041461_TRAP_INST_ACCESS;

    typedef enum logic [1:0] {
        StIdle,
        StAr,
        StR,
        StHold
    } state_e;

    state_e      state_q;
    logic [63:0] pc_q;
    logic        discard_q;
    logic [63:0] araddr_q;
    logic [63:0] pc_out_q;
    logic [63:0] rdata_out_q;
    logic        valid_out_q;
    logic [3:0]  trap_out_q;

    // Single-beat bursts only; rlast carries no information for us.
    logic unused_rlast;
    assign unused_rlast = rlast;

    // Fetch FSM: PC, in-flight bookkeeping and the registered IF2-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            pc_q        <= RESET_PC;
            discard_q   <= 1'b0;
            araddr_q    <= 64'd0;
            pc_out_q    <= RESET_PC;
            rdata_out_q <= 64'd0;
            valid_out_q <= 1'b0;
            trap_out_q  <= TRAP_NOP;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_pc;
                    end else if (pc_q[1:0] != 2'b00) begin
                        // Misaligned PC traps without touching the bus.
                        pc_out_q    <= pc_q;
                        rdata_out_q <= 64'd0;
                        trap_out_q  <= TRAP_INST_MISALIGN;
                        valid_out_q <= 1'b1;
                        state_q     <= StHold;
                    end else begin
                        araddr_q <= {pc_q[63:3], 3'b000};
                        state_q  <= StAr;
                    end
                end
                StAr: begin
                    // arvalid cannot be withdrawn, so a redirect only marks the
                    // eventual beat as stale.
                    if (redirect_valid) begin
                        pc_q      <= redirect_pc;
                        discard_q <= 1'b1;
                    end
                    if (arready) begin
                        state_q <= StR;
                    end
                end
                StR: begin
                    if (rvalid) begin
                        if (discard_q || redirect_valid) begin
                            if (redirect_valid) begin
                                pc_q <= redirect_pc;
                            end
                            discard_q <= 1'b0;
                            state_q   <= StIdle;
                        end else begin
                            pc_out_q    <= pc_q;
                            rdata_out_q <= (rresp != 2'b00) ? 64'd0 : rdata;
                            trap_out_q  <= (rresp != 2'b00) ? TRAP_INST_ACCESS : TRAP_NOP;
                            valid_out_q <= 1'b1;
                            state_q     <= StHold;
                        end
                    end else if (redirect_valid) begin
                        pc_q      <= redirect_pc;
                        discard_q <= 1'b1;
                    end
                end
                StHold: begin
                    // Redirect beats acceptance: the presented fetch is on a dead path.
                    if (redirect_valid) begin
                        pc_q        <= redirect_pc;
                        valid_out_q <= 1'b0;
                        state_q     <= StIdle;
                    end else if (IF1_ready_in) begin
                        pc_q        <= pc_q + 64'd4;
                        valid_out_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign arvalid = (state_q == StAr);
    assign rready  = (state_q == StR);
    assign araddr  = araddr_q;
    assign arlen   = 8'd0;
    assign arsize  = 3'b011;
    assign arburst = 2'b01;

    assign IF1_pc_out    = pc_out_q;
    assign IF1_rdata_out = rdata_out_q;
    assign IF1_valid_out = valid_out_q;
    assign IF1_trap_out  = trap_out_q;

endmodule

// File: tb/tb_ysyx_041461_if1_fetch.sv
// Directed bench for the IF1 fetch stage with a scoreboard of expected presentations.

`ifndef ysyx_041461_TRAP_NOP
`define ysyx_041461_TRAP_NOP 4'd0
`endif
`ifndef ysyx_041461_TRAP_INST_MISALIGN
`define ysyx_041461_TRAP_INST_MISALIGN 4'd1
`endif
`ifndef ysyx_041461_TRAP_INST_ACCESS
`define ysyx_041461_TRAP_INST_ACCESS 4'd2
`endif

module tb_ysyx_041461_if1_fetch;

    localparam logic [63:0] RST_PC = 64'h0000_0000_3000_0000;
    localparam logic [3:0]  T_NOP  = `ysyx_041461_TRAP_NOP;
    localparam logic [3:0]  T_MIS  = `ysyx_041461_TRAP_INST_MISALIGN;
    localparam logic [3:0]  T_ACC  = `ysyx_041461_TRAP_INST_ACCESS;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [63:0] redirect_pc = 64'd0;
    logic        IF1_ready_in = 1'b0;
    logic [63:0] IF1_pc_out;
    logic [63:0] IF1_rdata_out;
    logic        IF1_valid_out;
    logic [3:0]  IF1_trap_out;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [63:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [63:0] rdata = 64'd0;
    logic [1:0]  rresp = 2'b00;
    logic        rlast = 1'b0;

    ysyx_041461_if1_fetch #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .IF1_ready_in   (IF1_ready_in),
        .IF1_pc_out     (IF1_pc_out),
        .IF1_rdata_out  (IF1_rdata_out),
        .IF1_valid_out  (IF1_valid_out),
        .IF1_trap_out   (IF1_trap_out),
        .arvalid        (arvalid),
        .arready        (arready),
        .araddr         (araddr),
        .arlen          (arlen),
        .arsize         (arsize),
        .arburst        (arburst),
        .rvalid         (rvalid),
        .rready         (rready),
        .rdata          (rdata),
        .rresp          (rresp),
        .rlast          (rlast)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [63:0] pc;
        logic [63:0] rdata;
        logic [3:0]  trap;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for an AR request, check its address, then handshake it.
    task automatic ar_handshake(input string tag, input logic [63:0] exp_addr);
        int n = 0;
        while (arvalid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_arvalid"}, 64'(arvalid), 64'd1);
        check({tag, "_araddr"}, araddr, exp_addr);
        arready = 1'b1;
        tick();
        arready = 1'b0;
    endtask

    // Deliver one R beat after `delay` idle cycles; queue the expected result if it must appear.
    task automatic r_beat(input string tag, input logic [63:0] data, input logic [1:0] resp,
                          input int delay, input logic push, input exp_t e);
        for (int i = 0; i < delay; i++) tick();
        check({tag, "_rready"}, 64'(rready), 64'd1);
        rvalid = 1'b1;
        rdata  = data;
        rresp  = resp;
        if (push) sb.push_back(e);
        tick();
        rvalid = 1'b0;
    endtask

    task automatic wait_present(input string tag);
        int n = 0;
        while (IF1_valid_out !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, 64'(IF1_valid_out), 64'd1);
    endtask

    task automatic pop_present(input string tag);
        exp_t e;
        check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_pc"}, IF1_pc_out, e.pc);
            check({tag, "_rdata"}, IF1_rdata_out, e.rdata);
            check({tag, "_trap"}, 64'(IF1_trap_out), 64'(e.trap));
        end
    endtask

    task automatic accept();
        IF1_ready_in = 1'b1;
        tick();
        IF1_ready_in = 1'b0;
        check("accept_valid_drop", 64'(IF1_valid_out), 64'd0);
    endtask

    initial begin
        int unsigned rel;
        int unsigned c0;
        logic [63:0] held_pc;
        logic [63:0] held_rdata;

        // Reset values
        tick();
        tick();
        check("rst_arvalid", 64'(arvalid), 64'd0);
        check("rst_araddr", araddr, 64'd0);
        check("rst_rready", 64'(rready), 64'd0);
        check("rst_valid", 64'(IF1_valid_out), 64'd0);
        check("rst_pc_out", IF1_pc_out, RST_PC);
        check("rst_rdata", IF1_rdata_out, 64'd0);
        check("rst_trap", 64'(IF1_trap_out), 64'(T_NOP));
        check("axi_consts", {41'd0, arlen, arsize, arburst, 10'd0},
              {41'd0, 8'd0, 3'b011, 2'b01, 10'd0});

        // First fetch with immediate handshakes: valid 3 cycles after release
        rst = 1'b0;
        rel = cyc;
        tick();
        check("f1_arvalid", 64'(arvalid), 64'd1);
        check("f1_araddr", araddr, 64'h3000_0000);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        r_beat("f1", 64'h0000_0013_0000_0013, 2'b00, 0, 1'b1,
               '{pc: 64'h3000_0000, rdata: 64'h0000_0013_0000_0013, trap: T_NOP});
        check("f1_latency", 64'(cyc - rel), 64'd3);
        check("f1_valid", 64'(IF1_valid_out), 64'd1);
        pop_present("f1");

        // Back-to-back fetch: same 8-byte word, pc + 4, one fetch per 4 cycles
        c0 = cyc;
        accept();
        ar_handshake("f2", 64'h3000_0000);
        r_beat("f2", 64'h1111_2222_3333_4444, 2'b00, 0, 1'b1,
               '{pc: 64'h3000_0004, rdata: 64'h1111_2222_3333_4444, trap: T_NOP});
        check("f2_throughput", 64'(cyc - c0), 64'd4);
        wait_present("f2");
        pop_present("f2");

        // Stall in HOLD for 5 cycles
        held_pc    = 64'h3000_0004;
        held_rdata = 64'h1111_2222_3333_4444;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_valid", 64'(IF1_valid_out), 64'd1);
            check("hold_pc", IF1_pc_out, held_pc);
            check("hold_rdata", IF1_rdata_out, held_rdata);
            check("hold_no_ar", 64'(arvalid), 64'd0);
        end
        accept();
        ar_handshake("f3", 64'h3000_0008);
        r_beat("f3", 64'h5555_6666_7777_8888, 2'b00, 0, 1'b1,
               '{pc: 64'h3000_0008, rdata: 64'h5555_6666_7777_8888, trap: T_NOP});
        wait_present("f3");
        pop_present("f3");
        accept();

        // Redirect while waiting in R: the late beat must be dropped
        ar_handshake("f4", 64'h3000_0008);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h8000_0000;
        tick();
        redirect_valid = 1'b0;
        r_beat("f4", 64'hDEAD_BEEF_DEAD_BEEF, 2'b00, 1, 1'b0, '0);
        check("f4_dropped", 64'(IF1_valid_out), 64'd0);
        ar_handshake("f5", 64'h8000_0000);
        r_beat("f5", 64'h0000_0073_0000_0013, 2'b00, 0, 1'b1,
               '{pc: 64'h8000_0000, rdata: 64'h0000_0073_0000_0013, trap: T_NOP});
        wait_present("f5");
        pop_present("f5");
        accept();

        // Redirect and ready together in HOLD; redirect target is misaligned
        ar_handshake("f6", 64'h8000_0000);
        r_beat("f6", 64'h0000_0073_0000_0013, 2'b00, 0, 1'b1,
               '{pc: 64'h8000_0004, rdata: 64'h0000_0073_0000_0013, trap: T_NOP});
        wait_present("f6");
        pop_present("f6");
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000_0002;
        IF1_ready_in   = 1'b1;
        sb.push_back('{pc: 64'h3000_0002, rdata: 64'd0, trap: T_MIS});
        tick();
        redirect_valid = 1'b0;
        IF1_ready_in   = 1'b0;
        check("mis_idle_valid", 64'(IF1_valid_out), 64'd0);
        check("mis_idle_no_ar", 64'(arvalid), 64'd0);
        tick();
        check("mis_no_ar", 64'(arvalid), 64'd0);
        check("mis_valid", 64'(IF1_valid_out), 64'd1);
        pop_present("mis");

        // Redirect out of the trap, then a bus error response
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000_0100;
        tick();
        redirect_valid = 1'b0;
        ar_handshake("err", 64'h3000_0100);
        r_beat("err", 64'h1234_5678_9ABC_DEF0, 2'b10, 0, 1'b1,
               '{pc: 64'h3000_0100, rdata: 64'd0, trap: T_ACC});
        wait_present("err");
        pop_present("err");
        accept();

        // Two redirects while AR is stalled: araddr stable, last redirect wins
        tick();
        check("arstall_arvalid", 64'(arvalid), 64'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 64'h3000_0200;
        tick();
        check("arstall_araddr", araddr, 64'h3000_0100);
        redirect_pc    = 64'h3000_0300;
        tick();
        redirect_valid = 1'b0;
        ar_handshake("arstall", 64'h3000_0100);
        r_beat("arstall", 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 1'b0, '0);
        check("arstall_dropped", 64'(IF1_valid_out), 64'd0);
        ar_handshake("f7", 64'h3000_0300);
        r_beat("f7", 64'h0000_0001_0000_0002, 2'b00, 0, 1'b1,
               '{pc: 64'h3000_0300, rdata: 64'h0000_0001_0000_0002, trap: T_NOP});
        wait_present("f7");
        pop_present("f7");
        accept();

        // Reset asserted mid-AR takes effect immediately
        tick();
        check("rstar_arvalid_pre", 64'(arvalid), 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rstar_arvalid", 64'(arvalid), 64'd0);
        check("rstar_pc_out", IF1_pc_out, RST_PC);
        check("rstar_valid", 64'(IF1_valid_out), 64'd0);
        tick();
        rst = 1'b0;
        ar_handshake("f8", RST_PC);
        r_beat("f8", 64'h0000_0013_0000_0013, 2'b00, 0, 1'b1,
               '{pc: RST_PC, rdata: 64'h0000_0013_0000_0013, trap: T_NOP});
        wait_present("f8");
        pop_present("f8");
        accept();

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
